// File: rtl/data_ram_wb.sv
// Word-organised data RAM with a ce/ack handshake and a configurable number of
// wait states; stalls the pipeline while an access is pending.
module data_ram_wb #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stall_req_o
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        lat_we;
    logic [31:2] lat_addr;
    logic [3:0]  lat_sel;
    logic [31:0] lat_data;

    logic [31:0] mem [DEPTH];

    logic                  acc_we;
    logic [31:2]           acc_addr;
    logic [3:0]            acc_sel;
    logic [31:0]           acc_data;
    logic                  acc_err;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  commit;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ^addr_i[1:0];

    // With no wait states the access commits straight out of IDLE, before the
    // request has been latched, so the live inputs are used in that state.
    always_comb begin
        acc_we   = lat_we;
        acc_addr = lat_addr;
        acc_sel  = lat_sel;
        acc_data = lat_data;
        if (state == IDLE) begin
            acc_we   = we_i;
            acc_addr = addr_i[31:2];
            acc_sel  = sel_i;
            acc_data = data_i;
        end
        acc_err = (acc_addr[31:ADDR_WIDTH+2] != '0);
        acc_idx = acc_addr[ADDR_WIDTH+1:2];
        commit  = !rst && (((state == IDLE) && ce_i && (WAIT_STATES == 0)) ||
                           ((state == WAIT) && (wait_cnt == '0)));
    end

    assign stall_req_o = !rst && (((state == IDLE) && ce_i) || (state == WAIT));

    always_ff @(posedge clk) begin
        if (commit && acc_we && !acc_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (acc_sel[i]) mem[acc_idx][i*8 +: 8] <= acc_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            data_o   <= '0;
            wait_cnt <= '0;
        end else begin
            ack_o  <= 1'b0;
            err_o  <= 1'b0;
            data_o <= '0;
            if (commit) begin
                state  <= ACK;
                ack_o  <= 1'b1;
                err_o  <= acc_err;
                data_o <= (!acc_we && !acc_err) ? mem[acc_idx] : '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ce_i) begin
                            lat_we   <= we_i;
                            lat_addr <= addr_i[31:2];
                            lat_sel  <= sel_i;
                            lat_data <= data_i;
                            state    <= WAIT;
                            wait_cnt <= 4'(WAIT_STATES - 1);
                        end
                    end
                    WAIT:    wait_cnt <= wait_cnt - 4'd1;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
